// File: rtl/snd_pkg.sv
// ---------------------------------------------------------------------------
// snd_pkg
// Shared definitions for the sound player: player state encoding, the
// half-period table for the twelve tone codes and the rest classifier.
// ---------------------------------------------------------------------------
package snd_pkg;

    localparam int CODE_W = 4;
    localparam int HALF_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NOTE = 2'd1,
        GAP  = 2'd2
    } snd_st_t;

    // Half-period in clk cycles at 50 MHz, round(50e6 / (2 * f)).
    // Codes 1..12 are C5..B5 chromatic; rest codes hold 0.
    localparam logic [HALF_W-1:0] HALF_TBL [0:15] = '{
        16'd0,
        16'd47778, 16'd45097, 16'd42566, 16'd40177, 16'd37922, 16'd35793,
        16'd33784, 16'd31888, 16'd30098, 16'd28409, 16'd26815, 16'd25310,
        16'd0,     16'd0,     16'd0
    };

    // Codes 0 and 13..15 play silence for a full note length.
    function automatic logic is_rest(input logic [CODE_W-1:0] code);
        return (code == '0) || (code > 4'd12);
    endfunction

endpackage

// File: rtl/snd_fifo.sv
// ---------------------------------------------------------------------------
// snd_fifo
// Circular-buffer FIFO with first-word fall-through output.
//   clk, resetN : clock, asynchronous active-low reset
//   push, din   : write request and data (ignored while full)
//   pop         : read request (ignored while empty), advances the head
//   clr         : synchronous flush, wins over push and pop
//   dout        : current head entry
//   full, empty : occupancy flags, decoded from the registered count
// ---------------------------------------------------------------------------
module snd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             push,
    input  logic             pop,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;
    assign dout      = r_mem[r_rd_ptr];

    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; slots outside the pointer window
    // are never observed, and leaving them unreset keeps them plain RAM.
    always_ff @(posedge clk) begin
        if (w_push_ok && !clr) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/sound_player.sv
// ---------------------------------------------------------------------------
// sound_player
// Queues 4-bit note codes and plays each as a square wave for NOTE_LEN
// cycles followed by GAP_LEN cycles of silence.
//   clk, resetN : 50 MHz clock, asynchronous active-low reset
//   sndCode     : note code (0, 13..15 rest; 1..12 C5..B5)
//   sndVld      : sndCode valid; accepted when sndRdy is high
//   sndRdy      : FIFO has room (combinational from registers)
//   sndClr      : synchronous flush of queue and current note/gap
//   audOut      : registered square-wave output
//   busy        : player active or queue non-empty (combinational)
//   noteNow     : registered code being played, 0 in IDLE and GAP
// ---------------------------------------------------------------------------
module sound_player
    import snd_pkg::*;
#(
    parameter int NOTE_LEN   = 12_500_000,
    parameter int GAP_LEN    = 1_250_000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic [CODE_W-1:0] sndCode,
    input  logic              sndVld,
    output logic              sndRdy,
    input  logic              sndClr,
    output logic              audOut,
    output logic              busy,
    output logic [CODE_W-1:0] noteNow
);

    localparam int DUR_MAX = (NOTE_LEN > GAP_LEN) ? NOTE_LEN : GAP_LEN;
    localparam int DUR_W   = (DUR_MAX > 1) ? $clog2(DUR_MAX) : 1;

    localparam logic [DUR_W-1:0] NOTE_LOAD = DUR_W'(NOTE_LEN - 1);
    localparam logic [DUR_W-1:0] GAP_LOAD  = DUR_W'(GAP_LEN - 1);

    snd_st_t r_state;
    snd_st_t w_state_nxt;

    logic              w_pop;
    logic [CODE_W-1:0] w_fifo_dout;
    logic              w_fifo_full;
    logic              w_fifo_empty;

    logic [HALF_W-1:0] r_half_cnt;
    logic [DUR_W-1:0]  r_dur_cnt;
    logic              r_aud;
    logic [CODE_W-1:0] r_note;

    logic [HALF_W-1:0] w_half_nxt;
    logic [DUR_W-1:0]  w_dur_nxt;
    logic              w_aud_nxt;
    logic [CODE_W-1:0] w_note_nxt;

    snd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CODE_W)
    ) u_fifo (
        .clk    (clk),
        .resetN (resetN),
        .push   (sndVld),
        .pop    (w_pop),
        .clr    (sndClr),
        .din    (sndCode),
        .dout   (w_fifo_dout),
        .full   (w_fifo_full),
        .empty  (w_fifo_empty)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // ---------------- next state / pop decision ----------------
    // A pop always coincides with entering NOTE, so it doubles as the
    // "load a new note" strobe for the datapath below.
    // NOTE: every signal assigned in an always_comb gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        if (sndClr) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_fifo_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = NOTE;
                    end
                end
                NOTE: begin
                    if (r_dur_cnt == '0) w_state_nxt = GAP;
                end
                GAP: begin
                    if (r_dur_cnt == '0) begin
                        // Chain straight into the next note with no IDLE cycle.
                        if (!w_fifo_empty) begin
                            w_pop       = 1'b1;
                            w_state_nxt = NOTE;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // ---------------- output / datapath next values ----------------
    always_comb begin
        w_half_nxt = r_half_cnt;
        w_dur_nxt  = r_dur_cnt;
        w_aud_nxt  = r_aud;
        w_note_nxt = r_note;
        if (sndClr) begin
            w_half_nxt = '0;
            w_dur_nxt  = '0;
            w_aud_nxt  = 1'b0;
            w_note_nxt = '0;
        end else if (w_pop) begin
            // Rest codes load a don't-care half count; NOTE never uses it.
            w_half_nxt = HALF_TBL[w_fifo_dout] - HALF_W'(1);
            w_dur_nxt  = NOTE_LOAD;
            w_aud_nxt  = 1'b0;
            w_note_nxt = w_fifo_dout;
        end else begin
            case (r_state)
                IDLE: begin
                    w_aud_nxt  = 1'b0;
                    w_note_nxt = '0;
                end
                NOTE: begin
                    if (r_dur_cnt == '0) begin
                        // Cut the wave wherever it is; the gap starts low.
                        w_aud_nxt  = 1'b0;
                        w_dur_nxt  = GAP_LOAD;
                        w_note_nxt = '0;
                    end else begin
                        w_dur_nxt = r_dur_cnt - DUR_W'(1);
                        if (is_rest(r_note)) begin
                            w_aud_nxt = 1'b0;
                        end else if (r_half_cnt == '0) begin
                            w_half_nxt = HALF_TBL[r_note] - HALF_W'(1);
                            w_aud_nxt  = !r_aud;
                        end else begin
                            w_half_nxt = r_half_cnt - HALF_W'(1);
                        end
                    end
                end
                GAP: begin
                    w_aud_nxt = 1'b0;
                    // Saturate at 0 when falling back to IDLE.
                    if (r_dur_cnt != '0) w_dur_nxt = r_dur_cnt - DUR_W'(1);
                end
                default: begin
                    w_aud_nxt  = 1'b0;
                    w_note_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_half_cnt <= '0;
            r_dur_cnt  <= '0;
            r_aud      <= 1'b0;
            r_note     <= '0;
        end else begin
            r_half_cnt <= w_half_nxt;
            r_dur_cnt  <= w_dur_nxt;
            r_aud      <= w_aud_nxt;
            r_note     <= w_note_nxt;
        end
    end

    assign sndRdy  = !w_fifo_full;
    assign busy    = (r_state != IDLE) || !w_fifo_empty;
    assign audOut  = r_aud;
    assign noteNow = r_note;

endmodule

// File: tb/tb_sound_player.sv
// ---------------------------------------------------------------------------
// tb_sound_player
// Two instances share one clock: u_tone has a note long enough for one
// half-period of code 12 (waveform and reset checks), dut has short
// note/gap lengths for queueing, back-pressure and flush checks.
// ---------------------------------------------------------------------------
module tb_sound_player;

    localparam int M_NOTE   = 400;
    localparam int M_GAP    = 40;
    localparam int M_P      = M_NOTE + M_GAP;
    localparam int T_NOTE   = 25_500;
    localparam int T_GAP    = 200;
    localparam int T_HALF12 = 25_310;   // B5 half-period at 50 MHz

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // main instance
    logic       resetN, sndVld, sndClr;
    logic [3:0] sndCode;
    logic       sndRdy, audOut, busy;
    logic [3:0] noteNow;

    // tone instance
    logic       t_resetN, t_vld, t_clr;
    logic [3:0] t_code;
    logic       t_rdy, t_aud, t_busy;
    logic [3:0] t_note;

    sound_player #(.NOTE_LEN(M_NOTE), .GAP_LEN(M_GAP), .FIFO_DEPTH(4)) dut (
        .clk(clk), .resetN(resetN), .sndCode(sndCode), .sndVld(sndVld),
        .sndRdy(sndRdy), .sndClr(sndClr), .audOut(audOut), .busy(busy),
        .noteNow(noteNow)
    );

    sound_player #(.NOTE_LEN(T_NOTE), .GAP_LEN(T_GAP), .FIFO_DEPTH(4)) u_tone (
        .clk(clk), .resetN(t_resetN), .sndCode(t_code), .sndVld(t_vld),
        .sndRdy(t_rdy), .sndClr(t_clr), .audOut(t_aud), .busy(t_busy),
        .noteNow(t_note)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard on main instance ----------------
    typedef struct {
        logic [3:0]  code;
        int unsigned spacing;   // cycles since previous note start, 0 = unchecked
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned last_start = 0;
    logic [3:0]  prev_note  = 4'd0;

    task automatic sb_exp(input logic [3:0] c, input int unsigned s);
        exp_t e;
        e.code    = c;
        e.spacing = s;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (noteNow !== 4'd0 && prev_note === 4'd0) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_note", noteNow, 0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_code", noteNow, mon_e.code);
                if (mon_e.spacing != 0) check("sb_spacing", cyc - last_start, mon_e.spacing);
            end
            last_start = cyc;
        end
        prev_note = noteNow;
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d compared, expected completion", n_cmp);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic [3:0] code;
        logic [3:0] exp_note;
        bit         exp_sb;
        int         exp_busy;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int   bp_rdy[6];
        int   first_rise, rises, last_note_n, gap_hi, w, busy_len, aud_hi;
        logic prev_aud, busy_gap_end, busy_idle, aud_note_end;
        logic [3:0] note0, note1;
        int unsigned e1;

        vecs[0] = '{4'd1,  4'd1,  1'b1, 1 + M_NOTE + M_GAP};
        vecs[1] = '{4'd5,  4'd5,  1'b1, 1 + M_NOTE + M_GAP};
        vecs[2] = '{4'd12, 4'd12, 1'b1, 1 + M_NOTE + M_GAP};
        vecs[3] = '{4'd0,  4'd0,  1'b0, 1 + M_NOTE + M_GAP};
        vecs[4] = '{4'd13, 4'd13, 1'b1, 1 + M_NOTE + M_GAP};
        vecs[5] = '{4'd15, 4'd15, 1'b1, 1 + M_NOTE + M_GAP};
        bp_rdy  = '{1, 1, 1, 1, 1, 0};

        resetN = 1'b0; sndVld = 1'b0; sndClr = 1'b0; sndCode = 4'd0;
        t_resetN = 1'b0; t_vld = 1'b0; t_clr = 1'b0; t_code = 4'd0;

        // ---- reset values ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_aud", audOut, 0);
        check("rst_busy", busy, 0);
        check("rst_note", noteNow, 0);
        check("rst_rdy", sndRdy, 1);
        resetN = 1'b1;
        t_resetN = 1'b1;
        @(negedge clk);
        check("rst_rel_busy", busy, 0);
        check("rst_rel_rdy", t_rdy, 1);
        tick();

        // ---- single tone note, code 12, on the long-note instance ----
        t_code = 4'd12;
        t_vld  = 1'b1;
        tick();
        t_vld  = 1'b0;
        @(negedge clk);
        check("tone_latency_early", t_note, 0);
        first_rise = -1; rises = 0; last_note_n = -1; gap_hi = 0;
        prev_aud = 1'b0; note0 = 4'd0; busy_gap_end = 1'b0; busy_idle = 1'b1; aud_note_end = 1'b0;
        for (int n = 0; n <= T_NOTE + T_GAP; n++) begin
            @(negedge clk);
            if (n == 0) note0 = t_note;
            if (t_note === 4'd12) last_note_n = n;
            if (first_rise < 0 && t_aud === 1'b1) first_rise = n;
            if (t_aud === 1'b1 && prev_aud === 1'b0) rises++;
            if (n == T_NOTE - 1) aud_note_end = t_aud;
            if (n >= T_NOTE && t_aud !== 1'b0) gap_hi++;
            if (n == T_NOTE + T_GAP - 1) busy_gap_end = t_busy;
            if (n == T_NOTE + T_GAP) busy_idle = t_busy;
            prev_aud = t_aud;
        end
        check("tone_entry_note", note0, 12);
        check("tone_first_rise", first_rise, T_HALF12);
        check("tone_rises", rises, 1);
        check("tone_aud_at_note_end", aud_note_end, 1);
        check("tone_note_last_cycle", last_note_n, T_NOTE - 1);
        check("tone_gap_high_cycles", gap_hi, 0);
        check("tone_busy_gap_end", busy_gap_end, 1);
        check("tone_busy_idle", busy_idle, 0);

        // ---- asynchronous reset mid-note with audOut high ----
        tick();
        t_code = 4'd12;
        t_vld  = 1'b1;
        tick();
        t_code = 4'd3;
        tick();
        t_vld  = 1'b0;
        w = 0;
        while (t_aud !== 1'b1 && w < 30_000) begin
            @(negedge clk);
            w++;
        end
        check("rst_mid_wait_rise", t_aud, 1);
        #2;
        t_resetN = 1'b0;
        #1;
        check("rst_mid_aud", t_aud, 0);
        check("rst_mid_busy", t_busy, 0);
        check("rst_mid_note", t_note, 0);
        check("rst_mid_rdy", t_rdy, 1);
        @(posedge clk);
        #1;
        t_resetN = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_queue_lost", t_busy, 0);
        tick();

        // ---- table-driven single notes on the main instance ----
        foreach (vecs[i]) begin
            if (vecs[i].exp_sb) sb_exp(vecs[i].code, 0);
            sndCode = vecs[i].code;
            sndVld  = 1'b1;
            tick();
            sndVld  = 1'b0;
            busy_len = 0; aud_hi = 0; note1 = 4'hx;
            while (busy_len < 2000) begin
                @(negedge clk);
                if (busy !== 1'b1) break;
                busy_len++;
                if (busy_len == 2) note1 = noteNow;
                if (audOut === 1'b1) aud_hi++;
            end
            check("vec_busy_len", busy_len, vecs[i].exp_busy);
            check("vec_note", note1, vecs[i].exp_note);
            check("vec_aud_high", aud_hi, 0);
            tick();
        end
        check("vec_sb_empty", sb.size(), 0);

        // ---- back-pressure, then push on GAP-end pop (full, then 3 queued) ----
        sb_exp(4'd1, 0);
        sb_exp(4'd2, M_P);
        sb_exp(4'd3, M_P);
        sb_exp(4'd4, M_P);
        sb_exp(4'd5, M_P);
        sb_exp(4'd7, M_P);
        for (int c = 1; c <= 6; c++) begin
            sndCode = 4'(c);
            sndVld  = 1'b1;
            @(negedge clk);
            check("bp_rdy", sndRdy, bp_rdy[c-1]);
            @(posedge clk);
            #1;
        end
        sndVld = 1'b0;
        e1 = last_start;
        while (cyc < e1 + M_P - 1) tick();
        sndCode = 4'd9;
        sndVld  = 1'b1;
        @(negedge clk);
        check("pp_full_rdy", sndRdy, 0);
        @(posedge clk);
        #1;
        sndVld = 1'b0;
        @(negedge clk);
        check("pp_rdy_after_pop", sndRdy, 1);
        check("pp_note2", noteNow, 2);
        tick();
        while (cyc < e1 + 2 * M_P - 1) tick();
        sndCode = 4'd7;
        sndVld  = 1'b1;
        @(negedge clk);
        check("pp3_rdy_before", sndRdy, 1);
        @(posedge clk);
        #1;
        sndVld = 1'b0;
        @(negedge clk);
        check("pp3_rdy_after", sndRdy, 1);
        check("pp3_note3", noteNow, 3);
        w = 0;
        while (busy === 1'b1 && w < 6 * M_P) begin
            @(negedge clk);
            w++;
        end
        check("bp_drain_idle", busy, 0);
        check("bp_sb_empty", sb.size(), 0);

        // ---- flush during NOTE with two queued and a concurrent push ----
        tick();
        sb_exp(4'd1, 0);
        sndVld = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            sndCode = 4'(c);
            tick();
        end
        sndVld = 1'b0;
        repeat (50) tick();
        check("fl_pre_note", noteNow, 1);
        sndClr  = 1'b1;
        sndVld  = 1'b1;
        sndCode = 4'd8;
        @(posedge clk);
        #1;
        sndClr = 1'b0;
        sndVld = 1'b0;
        @(negedge clk);
        check("fl_note", noteNow, 0);
        check("fl_aud", audOut, 0);
        check("fl_busy", busy, 0);
        check("fl_rdy", sndRdy, 1);
        repeat (2 * M_P) @(negedge clk);
        check("fl_still_idle", busy, 0);
        check("fl_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
